uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
- Receive-side controller for the UART RX path.
- Detects the start bit and generates the oversampling edge count and sample enable consumed by the data_sampling stage.
- Consumes the voted sampled_bit to deserialize an 8-bit LSB-first frame with optional parity.
- Checks parity and stop bit, then delivers a parallel byte with a one-cycle valid strobe to the system-side synchronizer.

Parameters:
DATA_W, 8, payload bits per frame (only 8 is required to be verified)

Ports:
clk  in  1  single clock for the whole block
rst  in  1  synchronous reset, active-low; all state cleared on a clk rising edge when rst==0
rx_in  in  1  serial line, idle high; already synchronized to clk
prescale  in  6  oversampling ratio; legal values are even, 6..32
par_en  in  1  1 = frame carries a parity bit
par_typ  in  1  0 = even parity, 1 = odd parity
sampled_bit  in  1  majority-voted bit from data_sampling
data_sample_en  out  1  sampling enable to data_sampling
edge_cnt  out  6  oversampling edge counter to data_sampling
cfg_prescale  out  6  prescale latched at frame start; drives data_sampling
p_data  out  8  received byte
data_valid  out  1  one-cycle strobe; p_data is good
par_err  out  1  parity error flag for the last frame
stp_err  out  1  stop-bit error flag for the last frame

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - edge_cnt=0, data_sample_en=0, cfg_prescale=0, p_data=0x00, data_valid=0, par_err=0, stp_err=0.
  - The internal shift register and bit counter are cleared.
  - Reset asserted mid-frame aborts the frame with no strobe and no flags.
- Notation: P = cfg_prescale; CHK = P/2+2 (the cycle in which sampled_bit reflects the vote of the current bit).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - data_sample_en=0, edge_cnt held at 0.
  - rx_in==0 -> START on the next edge.
  - On the same edge: latch prescale into cfg_prescale and latch par_en/par_typ; clear par_err and stp_err.
- Non-IDLE states:
  - data_sample_en=1.
  - edge_cnt counts 0..P-1 and wraps to 0; a wrap marks the end of a bit period.
  - The first START cycle has edge_cnt=0.
- START:
  - At edge_cnt==CHK, sampled_bit==1 means a glitch: go to IDLE, no flags, no strobe.
  - Otherwise, at edge_cnt==P-1 go to DATA with bit counter 0.
- DATA:
  - At CHK, shift sampled_bit into bit 7 of the shift register (shift right), so the first received bit ends up in p_data[0].
  - At P-1 on bit 7: go to PARITY if par_en, else go to STOP.
- PARITY:
  - At CHK, par_err_next = sampled_bit != expected.
  - Expected parity = XOR of the 8 data bits for even parity, inverted for odd parity.
  - At P-1 go to STOP.
- STOP:
  - At CHK, stp_err = ~sampled_bit, and par_err is registered. Both flags hold until the next START entry or reset.
  - On the same edge the state goes to IDLE. Leaving half a bit early allows back-to-back frames.
  - If both errors are 0, p_data is loaded from the shift register and data_valid=1 in the following cycle only.
  - If either error is 1, p_data holds its previous value and no strobe is issued.
- Configuration changes on prescale/par_en/par_typ mid-frame have no effect until the next START entry.
- rx_in is ignored outside IDLE except through sampled_bit.
- Frame latency, P=8, no parity: START entered at cycle 1, data_valid at cycle 80 (stop bit begins at cycle 73, CHK at cycle 79).
  - Each enabled parity bit adds P cycles.

Test Plan:
- P=8, par_en=0, frame 0x A5 sent LSB-first with stop=1 -> p_data=0xA5, data_valid high for exactly 1 cycle at cycle 80 relative to START entry, par_err=0, stp_err=0.
- P=16, par_en=1, par_typ=0, byte 0x37 (parity bit 1) -> p_data=0x37, valid strobe. Repeat with the parity bit sent as 0 -> par_err=1, no strobe, p_data keeps 0x37.
- P=8, par_en=1, par_typ=1, byte 0x00, parity bit 1, stop bit 0 -> stp_err=1, par_err=0, no strobe. Both flags clear on the next start.
- rx_in low for 2 cycles then high (glitch), P=8 -> return to IDLE after CHK (cycle 6 of START), no strobe, edge_cnt back at 0.
- Two back-to-back frames 0x55 then 0xAA with a single stop bit, P=32 -> two strobes, p_data=0x55 then 0xAA. Change prescale to 8 during frame 1 -> frame 1 still decoded at P=32.
- rst pulled low during the DATA bit 4 CHK cycle -> all outputs 0 on the next edge. A subsequent clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART RX controller, its line/config source and the
// data_sampling / system-side consumers.
interface uart_rx_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              rx_in;
    logic [5:0]        prescale;
    logic              par_en;
    logic              par_typ;
    logic              sampled_bit;
    logic              data_sample_en;
    logic [5:0]        edge_cnt;
    logic [5:0]        cfg_prescale;
    logic [DATA_W-1:0] p_data;
    logic              data_valid;
    logic              par_err;
    logic              stp_err;

    modport master (
        output rx_in, prescale, par_en, par_typ, sampled_bit,
        input  data_sample_en, edge_cnt, cfg_prescale, p_data, data_valid, par_err, stp_err
    );

    modport slave (
        input  rx_in, prescale, par_en, par_typ, sampled_bit,
        output data_sample_en, edge_cnt, cfg_prescale, p_data, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, oversampling edge count, LSB-first
// deserialization, parity/stop checking and one-cycle data_valid strobe.
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e            state_q;
    logic [5:0]        edge_cnt_q, edge_cnt_d;
    logic [5:0]        cfg_prescale_q;
    logic              sample_en_q;
    logic              par_en_q, par_typ_q;
    logic              par_pend_q, par_err_q, stp_err_q;
    logic              data_valid_q;
    logic [DATA_W-1:0] shift_q, p_data_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              at_chk, at_wrap;

    // at_chk is the cycle where data_sampling's vote for the current bit is valid
    always_comb begin
        at_wrap    = (edge_cnt_q == cfg_prescale_q - 6'd1);
        at_chk     = (edge_cnt_q == (cfg_prescale_q >> 1) + 6'd2);
        edge_cnt_d = at_wrap ? 6'd0 : edge_cnt_q + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            edge_cnt_q     <= '0;
            cfg_prescale_q <= '0;
            sample_en_q    <= 1'b0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_pend_q     <= 1'b0;
            par_err_q      <= 1'b0;
            stp_err_q      <= 1'b0;
            data_valid_q   <= 1'b0;
            shift_q        <= '0;
            p_data_q       <= '0;
            bit_cnt_q      <= '0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.rx_in) begin
                        state_q        <= START;
                        sample_en_q    <= 1'b1;
                        edge_cnt_q     <= '0;
                        cfg_prescale_q <= bus.prescale;
                        par_en_q       <= bus.par_en;
                        par_typ_q      <= bus.par_typ;
                        par_pend_q     <= 1'b0;
                        par_err_q      <= 1'b0;
                        stp_err_q      <= 1'b0;
                    end
                end
                START: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_chk && bus.sampled_bit) begin
                        state_q     <= IDLE;
                        sample_en_q <= 1'b0;
                        edge_cnt_q  <= '0;
                    end else if (at_wrap) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_chk)
                        shift_q <= {bus.sampled_bit, shift_q[DATA_W-1:1]};
                    if (at_wrap) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DATA_W - 1))
                            state_q <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_chk)
                        par_pend_q <= (bus.sampled_bit != ((^shift_q) ^ par_typ_q));
                    if (at_wrap)
                        state_q <= STOP;
                end
                STOP: begin
                    edge_cnt_q <= edge_cnt_d;
                    // Leave at mid stop bit so a following start bit is not missed
                    if (at_chk) begin
                        state_q     <= IDLE;
                        sample_en_q <= 1'b0;
                        edge_cnt_q  <= '0;
                        stp_err_q   <= ~bus.sampled_bit;
                        par_err_q   <= par_pend_q;
                        if (bus.sampled_bit && !par_pend_q) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_sample_en = sample_en_q;
    assign bus.edge_cnt       = edge_cnt_q;
    assign bus.cfg_prescale   = cfg_prescale_q;
    assign bus.p_data         = p_data_q;
    assign bus.data_valid     = data_valid_q;
    assign bus.par_err        = par_err_q;
    assign bus.stp_err        = stp_err_q;
endmodule
